// File: rtl/clock_ctrl.sv
// Button-driven mode controller and one-second tick scheduler for the digital clock datapath.
// Sequences time/stopwatch enables, edits and loads time/alarm fields, and gates the alarm buzzer.
module clock_ctrl #(
    parameter int unsigned TICK_DIV      = 100_000_000,
    parameter int unsigned ALARM_TIMEOUT = 60
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_mode,
    input  logic       btn_inc,
    input  logic       btn_ok,
    input  logic       alarm_hit,
    output logic [2:0] mode,
    output logic       start,
    output logic       stopwatch,
    output logic       stop,
    output logic       set_alarm,
    output logic       set_hours,
    output logic       set_mins,
    output logic       set_secs,
    output logic [4:0] edit_hours,
    output logic [5:0] edit_mins,
    output logic [5:0] edit_secs,
    output logic       alarm_en,
    output logic       alarm_out
);

    localparam int unsigned CNT_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned RING_W = (ALARM_TIMEOUT > 1) ? $clog2(ALARM_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(TICK_DIV - 1);
    localparam logic [RING_W-1:0] RING_LAST = RING_W'(ALARM_TIMEOUT - 1);

    typedef enum logic [2:0] {
        ST_RUN   = 3'd0,
        ST_SET_H = 3'd1,
        ST_SET_M = 3'd2,
        ST_SET_S = 3'd3,
        ST_AL_H  = 3'd4,
        ST_AL_M  = 3'd5,
        ST_AL_S  = 3'd6,
        ST_SW    = 3'd7
    } state_e;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [RING_W-1:0]   ring_q, ring_d;
    logic                btn_mode_q, btn_inc_q, btn_ok_q, alarm_hit_q;
    logic                sw_run_q, sw_run_d;
    logic                start_q, start_d;
    logic                stopwatch_q, stopwatch_d;
    logic                stop_q, stop_d;
    logic                set_alarm_q, set_alarm_d;
    logic                set_hours_q, set_hours_d;
    logic                set_mins_q, set_mins_d;
    logic                set_secs_q, set_secs_d;
    logic [4:0]          edit_hours_q, edit_hours_d;
    logic [5:0]          edit_mins_q, edit_mins_d;
    logic [5:0]          edit_secs_q, edit_secs_d;
    logic                alarm_en_q, alarm_en_d;
    logic                alarm_out_q, alarm_out_d;

    logic mode_edge_c, inc_edge_c, ok_edge_c, hit_edge_c, any_edge_c, tick_c;

    assign mode_edge_c = btn_mode & ~btn_mode_q;
    assign inc_edge_c  = btn_inc & ~btn_inc_q;
    assign ok_edge_c   = btn_ok & ~btn_ok_q;
    assign hit_edge_c  = alarm_hit & ~alarm_hit_q;
    assign any_edge_c  = mode_edge_c | inc_edge_c | ok_edge_c;
    assign tick_c      = (cnt_q == CNT_LAST);

    // State register; button history resets high so a button held through reset gives no edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_RUN;
            cnt_q        <= '0;
            ring_q       <= '0;
            btn_mode_q   <= 1'b1;
            btn_inc_q    <= 1'b1;
            btn_ok_q     <= 1'b1;
            alarm_hit_q  <= 1'b0;
            sw_run_q     <= 1'b0;
            start_q      <= 1'b0;
            stopwatch_q  <= 1'b0;
            stop_q       <= 1'b0;
            set_alarm_q  <= 1'b0;
            set_hours_q  <= 1'b0;
            set_mins_q   <= 1'b0;
            set_secs_q   <= 1'b0;
            edit_hours_q <= '0;
            edit_mins_q  <= '0;
            edit_secs_q  <= '0;
            alarm_en_q   <= 1'b0;
            alarm_out_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            ring_q       <= ring_d;
            btn_mode_q   <= btn_mode;
            btn_inc_q    <= btn_inc;
            btn_ok_q     <= btn_ok;
            alarm_hit_q  <= alarm_hit;
            sw_run_q     <= sw_run_d;
            start_q      <= start_d;
            stopwatch_q  <= stopwatch_d;
            stop_q       <= stop_d;
            set_alarm_q  <= set_alarm_d;
            set_hours_q  <= set_hours_d;
            set_mins_q   <= set_mins_d;
            set_secs_q   <= set_secs_d;
            edit_hours_q <= edit_hours_d;
            edit_mins_q  <= edit_mins_d;
            edit_secs_q  <= edit_secs_d;
            alarm_en_q   <= alarm_en_d;
            alarm_out_q  <= alarm_out_d;
        end
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d      = state_q;
        cnt_d        = tick_c ? '0 : cnt_q + CNT_W'(1);
        ring_d       = ring_q;
        sw_run_d     = sw_run_q;
        set_alarm_d  = 1'b0;
        set_hours_d  = 1'b0;
        set_mins_d   = 1'b0;
        set_secs_d   = 1'b0;
        edit_hours_d = edit_hours_q;
        edit_mins_d  = edit_mins_q;
        edit_secs_d  = edit_secs_q;
        alarm_en_d   = alarm_en_q;
        alarm_out_d  = alarm_out_q;

        // Ring timeout, then restart on a fresh hit.
        if (alarm_out_q && tick_c) begin
            if (ring_q == RING_LAST) begin
                alarm_out_d = 1'b0;
            end else begin
                ring_d = ring_q + RING_W'(1);
            end
        end
        if (hit_edge_c && alarm_en_q) begin
            alarm_out_d = 1'b1;
            ring_d      = '0;
        end

        // A ringing alarm swallows every button edge.
        if (alarm_out_q && any_edge_c) begin
            alarm_out_d = 1'b0;
        end else if (mode_edge_c) begin
            state_d = state_e'(state_q + 3'd1);
            if (state_q == ST_AL_S) begin
                sw_run_d = 1'b0;
            end
        end else if (ok_edge_c) begin
            case (state_q)
                ST_SET_H: set_hours_d = 1'b1;
                ST_SET_M: set_mins_d  = 1'b1;
                ST_SET_S: set_secs_d  = 1'b1;
                ST_AL_H: begin
                    set_hours_d = 1'b1;
                    set_alarm_d = 1'b1;
                end
                ST_AL_M: begin
                    set_mins_d  = 1'b1;
                    set_alarm_d = 1'b1;
                end
                ST_AL_S: begin
                    set_secs_d  = 1'b1;
                    set_alarm_d = 1'b1;
                end
                ST_SW:   sw_run_d = ~sw_run_q;
                default: ;
            endcase
        end else if (inc_edge_c) begin
            case (state_q)
                ST_RUN: alarm_en_d = ~alarm_en_q;
                ST_SET_H, ST_AL_H:
                    edit_hours_d = (edit_hours_q == 5'd23) ? 5'd0 : edit_hours_q + 5'd1;
                ST_SET_M, ST_AL_M:
                    edit_mins_d = (edit_mins_q == 6'd59) ? 6'd0 : edit_mins_q + 6'd1;
                ST_SET_S, ST_AL_S:
                    edit_secs_d = (edit_secs_q == 6'd59) ? 6'd0 : edit_secs_q + 6'd1;
                default: ;
            endcase
        end

        if (!alarm_en_d) begin
            alarm_out_d = 1'b0;
        end

        // Tick pulses are dropped in the cycle their mode is left.
        start_d     = tick_c && (state_q == ST_RUN) && (state_d == ST_RUN);
        stopwatch_d = tick_c && (state_q == ST_SW) && (state_d == ST_SW) && sw_run_d;
        stop_d      = (state_d == ST_SW) && !sw_run_d;
    end

    assign mode       = state_q;
    assign start      = start_q;
    assign stopwatch  = stopwatch_q;
    assign stop       = stop_q;
    assign set_alarm  = set_alarm_q;
    assign set_hours  = set_hours_q;
    assign set_mins   = set_mins_q;
    assign set_secs   = set_secs_q;
    assign edit_hours = edit_hours_q;
    assign edit_mins  = edit_mins_q;
    assign edit_secs  = edit_secs_q;
    assign alarm_en   = alarm_en_q;
    assign alarm_out  = alarm_out_q;

endmodule

// File: tb/tb_clock_ctrl.sv
// Scoreboard bench for clock_ctrl: stimulus queues expectations, a negedge monitor pops and compares.
module tb_clock_ctrl;

    localparam int unsigned TICK_DIV      = 4;
    localparam int unsigned ALARM_TIMEOUT = 3;

    localparam int ID_MODE   = 0;
    localparam int ID_STOP   = 1;
    localparam int ID_AL_EN  = 2;
    localparam int ID_AL_OUT = 3;
    localparam int ID_EH     = 4;
    localparam int ID_EM     = 5;
    localparam int ID_ES     = 6;
    localparam int ID_START  = 7;

    localparam int B_MODE     = 0;
    localparam int B_INC      = 1;
    localparam int B_OK       = 2;
    localparam int B_MODE_INC = 3;

    logic       clk = 1'b0;
    logic       reset;
    logic       btn_mode, btn_inc, btn_ok, alarm_hit;
    logic [2:0] mode;
    logic       start, stopwatch, stop;
    logic       set_alarm, set_hours, set_mins, set_secs;
    logic [4:0] edit_hours;
    logic [5:0] edit_mins, edit_secs;
    logic       alarm_en, alarm_out;

    typedef struct {
        int cyc;
        int id;
        int val;
    } lvl_t;

    typedef struct {
        int         cyc;
        logic [3:0] flags;
        logic [4:0] h;
        logic [5:0] m;
        logic [5:0] s;
    } stb_t;

    lvl_t lvl_q[$];
    stb_t stb_q[$];
    int   start_q[$];
    int   sw_q[$];
    bit   track_start = 1'b0;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_errors = 0;
    int   rel, o_cyc, h_cyc, w3, nwrap;

    clock_ctrl #(
        .TICK_DIV      (TICK_DIV),
        .ALARM_TIMEOUT (ALARM_TIMEOUT)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .btn_mode   (btn_mode),
        .btn_inc    (btn_inc),
        .btn_ok     (btn_ok),
        .alarm_hit  (alarm_hit),
        .mode       (mode),
        .start      (start),
        .stopwatch  (stopwatch),
        .stop       (stop),
        .set_alarm  (set_alarm),
        .set_hours  (set_hours),
        .set_mins   (set_mins),
        .set_secs   (set_secs),
        .edit_hours (edit_hours),
        .edit_mins  (edit_mins),
        .edit_secs  (edit_secs),
        .alarm_en   (alarm_en),
        .alarm_out  (alarm_out)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
        end
    endtask

    function automatic int sig_val(input int id);
        case (id)
            ID_MODE:   return 32'(mode);
            ID_STOP:   return 32'(stop);
            ID_AL_EN:  return 32'(alarm_en);
            ID_AL_OUT: return 32'(alarm_out);
            ID_EH:     return 32'(edit_hours);
            ID_EM:     return 32'(edit_mins);
            ID_ES:     return 32'(edit_secs);
            default:   return 32'(start);
        endcase
    endfunction

    function automatic string sig_name(input int id);
        case (id)
            ID_MODE:   return "mode";
            ID_STOP:   return "stop";
            ID_AL_EN:  return "alarm_en";
            ID_AL_OUT: return "alarm_out";
            ID_EH:     return "edit_hours";
            ID_EM:     return "edit_mins";
            ID_ES:     return "edit_secs";
            default:   return "start_level";
        endcase
    endfunction

    // Monitor: compares whatever the DUT presents against the head of each expectation queue.
    always @(negedge clk) begin : monitor
        lvl_t le;
        stb_t se;
        int   ec;
        while (lvl_q.size() > 0 && lvl_q[0].cyc <= cyc) begin
            le = lvl_q.pop_front();
            if (le.cyc < cyc) check("level_stale", cyc, le.cyc);
            else              check(sig_name(le.id), sig_val(le.id), le.val);
        end
        if (set_alarm | set_hours | set_mins | set_secs) begin
            if (stb_q.size() == 0) begin
                check("strobe_unexpected", 1, 0);
            end else begin
                se = stb_q.pop_front();
                check("strobe_cycle", cyc, se.cyc);
                check("strobe_flags", 32'({set_alarm, set_hours, set_mins, set_secs}), 32'(se.flags));
                check("strobe_fields", 32'({edit_hours, edit_mins, edit_secs}), 32'({se.h, se.m, se.s}));
            end
        end
        if (start && track_start) begin
            if (start_q.size() == 0) check("start_unexpected", 1, 0);
            else begin
                ec = start_q.pop_front();
                check("start_cycle", cyc, ec);
            end
        end
        if (stopwatch) begin
            if (sw_q.size() == 0) check("stopwatch_unexpected", 1, 0);
            else begin
                ec = sw_q.pop_front();
                check("stopwatch_cycle", cyc, ec);
            end
        end
    end

    task automatic expect_lvl(input int id, input int val);
        lvl_t e;
        e.cyc = cyc;
        e.id  = id;
        e.val = val;
        lvl_q.push_back(e);
    endtask

    task automatic expect_stb(input logic [3:0] flags, input logic [4:0] h,
                              input logic [5:0] m, input logic [5:0] s);
        stb_t e;
        e.cyc   = cyc;
        e.flags = flags;
        e.h     = h;
        e.m     = m;
        e.s     = s;
        stb_q.push_back(e);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drives a one-cycle press; returns just after the edge that acts on it.
    task automatic press(input int which);
        btn_mode = (which == B_MODE) || (which == B_MODE_INC);
        btn_inc  = (which == B_INC)  || (which == B_MODE_INC);
        btn_ok   = (which == B_OK);
        step(1);
        btn_mode = 1'b0;
        btn_inc  = 1'b0;
        btn_ok   = 1'b0;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
        $fatal(1);
    end

    initial begin : stim
        reset     = 1'b1;
        btn_mode  = 1'b1;
        btn_inc   = 1'b0;
        btn_ok    = 1'b0;
        alarm_hit = 1'b0;

        // Reset with btn_mode held; first start pulses land 4, 8, 12 cycles after release.
        step(3);
        reset = 1'b0;
        rel   = cyc;
        expect_lvl(ID_MODE, 0);
        expect_lvl(ID_STOP, 0);
        expect_lvl(ID_AL_EN, 0);
        expect_lvl(ID_AL_OUT, 0);
        expect_lvl(ID_EH, 0);
        expect_lvl(ID_EM, 0);
        expect_lvl(ID_ES, 0);
        expect_lvl(ID_START, 0);
        track_start = 1'b1;
        start_q.push_back(rel + 4);
        start_q.push_back(rel + 8);
        start_q.push_back(rel + 12);
        step(2);
        btn_mode = 1'b0;
        step(1);
        expect_lvl(ID_MODE, 0);
        step(rel + 13 - cyc);
        track_start = 1'b0;
        check("start_pending", start_q.size(), 0);

        // Eight mode edges walk 1..7 and wrap to RUN; no start outside RUN.
        for (int k = 1; k <= 8; k++) begin
            press(B_MODE);
            if (k == 1) track_start = 1'b1;
            if (k == 8) track_start = 1'b0;
            expect_lvl(ID_MODE, k % 8);
            if (k == 7) expect_lvl(ID_STOP, 1);
            if (k == 8) expect_lvl(ID_STOP, 0);
            step(1);
        end

        // SET_H: 25 increments wrap 23->0 then land on 1.
        press(B_MODE);
        expect_lvl(ID_MODE, 1);
        step(1);
        for (int i = 1; i <= 25; i++) begin
            press(B_INC);
            if (i == 23) expect_lvl(ID_EH, 23);
            if (i == 24) expect_lvl(ID_EH, 0);
            if (i == 25) expect_lvl(ID_EH, 1);
            step(1);
        end
        press(B_OK);
        expect_stb(4'b0100, 5'd1, 6'd0, 6'd0);
        expect_lvl(ID_MODE, 1);
        step(1);

        // AL_M: one increment, load with set_alarm.
        for (int k = 0; k < 4; k++) begin
            press(B_MODE);
            step(1);
        end
        expect_lvl(ID_MODE, 5);
        press(B_INC);
        expect_lvl(ID_EM, 1);
        step(1);
        press(B_OK);
        expect_stb(4'b1010, 5'd1, 6'd1, 6'd0);
        step(1);

        // AL_S: 60 increments wrap back to 0.
        press(B_MODE);
        expect_lvl(ID_MODE, 6);
        step(1);
        for (int i = 1; i <= 60; i++) begin
            press(B_INC);
            if (i == 59) expect_lvl(ID_ES, 59);
            if (i == 60) expect_lvl(ID_ES, 0);
            step(1);
        end
        press(B_OK);
        expect_stb(4'b1001, 5'd1, 6'd1, 6'd0);
        step(1);

        // Stopwatch run/freeze, then back to RUN.
        press(B_MODE);
        expect_lvl(ID_MODE, 7);
        expect_lvl(ID_STOP, 1);
        step(2);
        press(B_OK);
        o_cyc = cyc;
        expect_lvl(ID_STOP, 0);
        for (int e = o_cyc; e < o_cyc + 12; e++) begin
            if ((e - rel) % 4 == 0) sw_q.push_back(e);
        end
        step(11);
        press(B_OK);
        expect_lvl(ID_STOP, 1);
        step(8);
        check("stopwatch_pending", sw_q.size(), 0);
        press(B_MODE);
        expect_lvl(ID_MODE, 0);
        expect_lvl(ID_STOP, 0);
        step(1);

        // Arm alarm, ring, and auto-silence after three ticks.
        press(B_INC);
        expect_lvl(ID_AL_EN, 1);
        expect_lvl(ID_AL_OUT, 0);
        step(1);
        alarm_hit = 1'b1;
        step(1);
        h_cyc = cyc;
        expect_lvl(ID_AL_OUT, 1);
        nwrap = 0;
        w3    = h_cyc;
        while (nwrap < 3) begin
            w3++;
            if ((w3 - rel) % 4 == 0) nwrap++;
        end
        if (w3 - 1 > h_cyc) begin
            lvl_t e;
            e.cyc = w3 - 1; e.id = ID_AL_OUT; e.val = 1;
            lvl_q.push_back(e);
        end
        begin
            lvl_t e;
            e.cyc = w3; e.id = ID_AL_OUT; e.val = 0;
            lvl_q.push_back(e);
            e.id = ID_AL_EN; e.val = 1;
            lvl_q.push_back(e);
        end
        step(1);
        alarm_hit = 1'b0;
        step(w3 + 1 - cyc);

        // Re-trigger, then a mode edge only silences.
        alarm_hit = 1'b1;
        step(1);
        expect_lvl(ID_AL_OUT, 1);
        alarm_hit = 1'b0;
        step(1);
        press(B_MODE);
        expect_lvl(ID_AL_OUT, 0);
        expect_lvl(ID_MODE, 0);
        step(1);
        expect_lvl(ID_MODE, 0);

        // Re-trigger, then an inc edge only silences; alarm stays armed.
        alarm_hit = 1'b1;
        step(1);
        expect_lvl(ID_AL_OUT, 1);
        alarm_hit = 1'b0;
        press(B_INC);
        expect_lvl(ID_AL_OUT, 0);
        expect_lvl(ID_AL_EN, 1);
        step(1);

        // Simultaneous mode+inc in RUN: mode wins.
        press(B_MODE_INC);
        expect_lvl(ID_MODE, 1);
        expect_lvl(ID_AL_EN, 1);
        step(1);

        // Reset mid-operation with btn_ok pressed: no strobe, all state cleared.
        reset  = 1'b1;
        btn_ok = 1'b1;
        step(1);
        expect_lvl(ID_MODE, 0);
        expect_lvl(ID_AL_EN, 0);
        expect_lvl(ID_EH, 0);
        expect_lvl(ID_EM, 0);
        expect_lvl(ID_STOP, 0);
        reset = 1'b0;
        step(1);
        btn_ok = 1'b0;
        step(3);
        expect_lvl(ID_MODE, 0);
        step(2);

        check("level_pending", lvl_q.size(), 0);
        check("strobe_pending", stb_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
